spi_cmd_arbiter: RTL and testbench

//  Shares one SPI master between two command requesters:
//   - port 0: boot-time ADC config sequencer
//   - port 1: runtime host register access

---
 rtl/spi_cmd_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_arbiter.sv
// rtl/spi_cmd_arbiter.sv - two-requester command arbiter in front of a shared SPI master
//
// Port 0 (boot ADC config sequencer) and port 1 (host register access) compete
// for one SPI master. One command is in flight at a time: its payload is latched
// onto spi_*, a start pulse is issued, spi_busy is tracked to completion, and
// exactly one response (id, read data, timeout error) is returned per command.
//
// Build option: SPI_ARB_RR_EN
//   undefined -> fixed priority, port 0 wins simultaneous requests
//   defined   -> round-robin, pointer favours the other port after every grant
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   rN_valid / rN_ready      request handshake for port N (N = 0, 1)
//   rN_adr, rN_dat           request address / write data
//   rN_rw, rN_cs             1 = read / chip-select selector
//   spi_start_o              one-cycle start pulse to the SPI master
//   spi_adr, spi_dat         latched address / data to the master
//   spi_rw, spi_cs_sel       latched direction / chip select to the master
//   spi_busy, spi_rd_dat     master busy, read data valid when busy falls
//   rsp_valid                one-cycle response strobe, no back-pressure
//   rsp_id, rsp_dat, rsp_err requester id, read data, timeout flag
//   arb_state_o              current FSM state
module spi_cmd_arbiter #(
    parameter int ACK_TMO  = 16,
    parameter int BUSY_TMO = 4096
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [15:0] r0_adr,
    input  logic [15:0] r0_dat,
    input  logic        r0_rw,
    input  logic        r0_cs,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [15:0] r1_adr,
    input  logic [15:0] r1_dat,
    input  logic        r1_rw,
    input  logic        r1_cs,
    output logic        spi_start_o,
    output logic [15:0] spi_adr,
    output logic [15:0] spi_dat,
    output logic        spi_rw,
    output logic        spi_cs_sel,
    input  logic        spi_busy,
    input  logic [15:0] spi_rd_dat,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_dat,
    output logic        rsp_err,
    output logic [2:0]  arb_state_o
);

    localparam int CW = $clog2(BUSY_TMO + 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TMO - 1);
    localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_TMO - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          grant;
    logic          gnt_id;
    logic          accept;

    // Saturating so a stuck count can never wrap back into a legal window.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // Port selected this cycle; only meaningful while IDLE.
`ifdef SPI_ARB_RR_EN
    logic rr_ptr;

    always_comb begin
        if (r0_valid && r1_valid) begin
            grant = rr_ptr;
        end else begin
            grant = r1_valid;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~grant;
        end
    end
`else
    assign grant = r1_valid & ~r0_valid;
`endif

    assign accept = (r0_valid & r0_ready) | (r1_valid & r1_ready);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (spi_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == ACK_LAST) begin
                    state_nxt = RESP;
                end
            end
            WAIT_DONE: begin
                if (!spi_busy || cnt == BUSY_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Ready is withheld during reset so every output reads 0 while aresetn is low.
    always_comb begin
        r0_ready    = 1'b0;
        r1_ready    = 1'b0;
        spi_start_o = 1'b0;
        rsp_valid   = 1'b0;
        arb_state_o = state;
        if (aresetn && state == IDLE && !spi_busy) begin
            r0_ready = ~grant;
            r1_ready = grant;
        end
        if (state == START) begin
            spi_start_o = 1'b1;
        end
        if (state == RESP) begin
            rsp_valid = 1'b1;
        end
    end

    // The START cycle counts toward the ack window, so the ack timeout response
    // lands exactly ACK_TMO cycles after the start pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            spi_adr    <= '0;
            spi_dat    <= '0;
            spi_rw     <= 1'b0;
            spi_cs_sel <= 1'b0;
            gnt_id     <= 1'b0;
            cnt        <= '0;
            rsp_id     <= 1'b0;
            rsp_dat    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        spi_adr    <= grant ? r1_adr : r0_adr;
                        spi_dat    <= grant ? r1_dat : r0_dat;
                        spi_rw     <= grant ? r1_rw  : r0_rw;
                        spi_cs_sel <= grant ? r1_cs  : r0_cs;
                        gnt_id     <= grant;
                        cnt        <= '0;
                    end
                end
                START: begin
                    cnt <= cnt_inc;
                end
                WAIT_BUSY: begin
                    if (spi_busy) begin
                        cnt <= '0;
                    end else if (cnt == ACK_LAST) begin
                        rsp_id  <= gnt_id;
                        rsp_dat <= '0;
                        rsp_err <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_DONE: begin
                    if (!spi_busy) begin
                        rsp_id  <= gnt_id;
                        rsp_dat <= spi_rw ? spi_rd_dat : 16'h0000;
                        rsp_err <= 1'b0;
                    end else if (cnt == BUSY_LAST) begin
                        rsp_id  <= gnt_id;
                        rsp_dat <= '0;
                        rsp_err <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// tb/tb_spi_cmd_arbiter.sv - randomized self-checking bench for spi_cmd_arbiter
`timescale 1ns/1ps
module tb_spi_cmd_arbiter;

    localparam int ACK_TMO  = 16;
    localparam int BUSY_TMO = 4096;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        r0_valid, r0_ready, r0_rw, r0_cs;
    logic [15:0] r0_adr, r0_dat;
    logic        r1_valid, r1_ready, r1_rw, r1_cs;
    logic [15:0] r1_adr, r1_dat;
    logic        spi_start_o, spi_rw, spi_cs_sel, spi_busy;
    logic [15:0] spi_adr, spi_dat, spi_rd_dat;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [15:0] rsp_dat;
    logic [2:0]  arb_state_o;

    spi_cmd_arbiter #(.ACK_TMO(ACK_TMO), .BUSY_TMO(BUSY_TMO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_adr(r0_adr), .r0_dat(r0_dat),
        .r0_rw(r0_rw), .r0_cs(r0_cs),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_adr(r1_adr), .r1_dat(r1_dat),
        .r1_rw(r1_rw), .r1_cs(r1_cs),
        .spi_start_o(spi_start_o), .spi_adr(spi_adr), .spi_dat(spi_dat),
        .spi_rw(spi_rw), .spi_cs_sel(spi_cs_sel),
        .spi_busy(spi_busy), .spi_rd_dat(spi_rd_dat),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .arb_state_o(arb_state_o)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [15:0] adr;
        logic [15:0] dat;
        logic        rw;
        logic        cs;
    } cmd_t;

    typedef struct packed {
        logic        id;
        logic [15:0] dat;
        logic        err;
    } rsp_t;

    cmd_t q0[$];
    cmd_t q1[$];
    rsp_t exp_q[$];
    int   grant_log[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Master model behaviour: 0 = normal, 1 = never raises busy, 2 = busy stuck high
    int   busy_mode     = 0;
    int   busy_len      = 5;
    logic stuck_release = 1'b0;
    logic rr_fav        = 1'b0;

    int          cyc = 0;
    int          t_start = 0;
    int          last_lat = 0;
    int          wd_cnt = 0;
    int          last_wd = 0;
    int          n_start = 0;
    int          n_rsp = 0;
    logic [15:0] last_rsp_dat = '0;
    logic        last_rsp_id = 1'b0;
    logic        last_rsp_err = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        return a ^ 16'h80A4;
    endfunction

    task automatic push_cmd(input logic port, input logic [15:0] adr, input logic [15:0] dat,
                            input logic rw, input logic cs);
        cmd_t c;
        c.adr = adr;
        c.dat = dat;
        c.rw  = rw;
        c.cs  = cs;
        if (port) q1.push_back(c);
        else q0.push_back(c);
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 &&
                     arb_state_o == 3'd0 && !spi_busy && !r0_valid && !r1_valid) &&
                   n < max_cyc);
        if (n >= max_cyc) check({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic wait_rsp(input int target, input int max_cyc, input string tag);
        int n = 0;
        while (n_rsp < target && n < max_cyc) begin
            @(negedge aclk);
            n++;
        end
        if (n_rsp < target) check({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    // Requester driver and arbitration/payload reference
    initial begin
        logic acc0, acc1, chk_pend, pred, got;
        cmd_t chk_cmd;
        rsp_t e;
        r0_valid = 0; r0_adr = 0; r0_dat = 0; r0_rw = 0; r0_cs = 0;
        r1_valid = 0; r1_adr = 0; r1_dat = 0; r1_rw = 0; r1_cs = 0;
        chk_pend = 0;
        chk_cmd  = '0;
        forever begin
            @(negedge aclk);
            if (chk_pend) begin
                check("spi_adr_dat", 64'({spi_adr, spi_dat}), 64'({chk_cmd.adr, chk_cmd.dat}));
                check("spi_rw_cs", 64'({spi_rw, spi_cs_sel}), 64'({chk_cmd.rw, chk_cmd.cs}));
                chk_pend = 0;
            end
            acc0 = r0_valid & r0_ready;
            acc1 = r1_valid & r1_ready;
            if (acc0 | acc1) begin
                check("single_accept", 64'(acc0 & acc1), 64'(0));
`ifdef SPI_ARB_RR_EN
                if (r0_valid && r1_valid) pred = rr_fav;
                else pred = r1_valid;
`else
                pred = r1_valid & ~r0_valid;
`endif
                got = acc1;
                check("grant", 64'(got), 64'(pred));
                rr_fav = ~got;
                grant_log.push_back(int'(got));
                chk_cmd = got ? q1[0] : q0[0];
                chk_pend = 1;
                e.id  = got;
                e.err = (busy_mode != 0);
                e.dat = (!e.err && chk_cmd.rw) ? model_rd(chk_cmd.adr) : 16'h0000;
                exp_q.push_back(e);
            end
            @(posedge aclk);
            #1;
            if (acc0 && q0.size() != 0) void'(q0.pop_front());
            if (acc1 && q1.size() != 0) void'(q1.pop_front());
            if (q0.size() != 0) begin
                r0_valid = 1; r0_adr = q0[0].adr; r0_dat = q0[0].dat; r0_rw = q0[0].rw; r0_cs = q0[0].cs;
            end else begin
                r0_valid = 0;
            end
            if (q1.size() != 0) begin
                r1_valid = 1; r1_adr = q1[0].adr; r1_dat = q1[0].dat; r1_rw = q1[0].rw; r1_cs = q1[0].cs;
            end else begin
                r1_valid = 0;
            end
        end
    end

    // SPI master model
    initial begin
        int          m_mode, m_len;
        logic [15:0] m_adr;
        spi_busy   = 0;
        spi_rd_dat = 0;
        forever begin
            @(negedge aclk);
            if (spi_start_o) begin
                m_mode = busy_mode;
                m_len  = busy_len;
                m_adr  = spi_adr;
                if (m_mode == 0) begin
                    @(posedge aclk);
                    #1 spi_busy = 1;
                    repeat (m_len) @(posedge aclk);
                    #1;
                    spi_busy   = 0;
                    spi_rd_dat = model_rd(m_adr);
                end else if (m_mode == 2) begin
                    @(posedge aclk);
                    #1 spi_busy = 1;
                    for (int i = 0; i < 20000 && !stuck_release; i++) @(posedge aclk);
                    #1 spi_busy = 0;
                end
            end
        end
    end

    // Response monitor / scoreboard
    initial begin
        rsp_t e;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (spi_start_o) begin
                    n_start++;
                    t_start = cyc;
                    wd_cnt  = 0;
                end
                if (arb_state_o == 3'd3) wd_cnt++;
                if (rsp_valid) begin
                    last_lat     = cyc - t_start;
                    last_wd      = wd_cnt;
                    last_rsp_dat = rsp_dat;
                    last_rsp_id  = rsp_id;
                    last_rsp_err = rsp_err;
                    n_rsp++;
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", 64'(rsp_id), 64'(e.id));
                        check("rsp_dat", 64'(rsp_dat), 64'(e.dat));
                        check("rsp_err", 64'(rsp_err), 64'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0c, t5_wd, n_push, base;
        logic t5_err;
        logic [15:0] t5_dat;
        aresetn = 0;
        repeat (3) @(negedge aclk);
        check("reset_outputs", 64'({spi_start_o, spi_adr, spi_dat, spi_rw, spi_cs_sel, rsp_valid,
                                    rsp_id, rsp_dat, rsp_err, arb_state_o, r0_ready, r1_ready}), 64'(0));
        aresetn = 1;
        @(negedge aclk);
        check("idle_state", 64'(arb_state_o), 64'(0));
        check("idle_ready", 64'({r0_ready, r1_ready}), 64'(2'b10));

        // 1: port 0 write, 40-cycle busy
        busy_mode = 0; busy_len = 40; s0 = n_start;
        push_cmd(0, 16'h0002, 16'h000D, 0, 0);
        wait_done(300, "t1");
        check("t1_start_pulses", 64'(n_start - s0), 64'(1));
        check("t1_spi_adr", 64'(spi_adr), 64'(16'h0002));
        check("t1_spi_dat", 64'(spi_dat), 64'(16'h000D));
        check("t1_rsp", 64'({last_rsp_id, last_rsp_err, last_rsp_dat}), 64'(0));

        // 2: port 1 read
        busy_len = 7;
        push_cmd(1, 16'h8001, 16'($urandom), 1, 1);
        wait_done(300, "t2");
        check("t2_rsp", 64'({last_rsp_id, last_rsp_err, last_rsp_dat}), 64'({1'b1, 1'b0, 16'h00A5}));
        check("t2_hold", 64'({rsp_valid, rsp_id, rsp_dat}), 64'({1'b0, 1'b1, 16'h00A5}));

        // 3: both ports with four commands each
        grant_log.delete();
        busy_len = 3;
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            push_cmd(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        wait_done(1000, "t3");
        check("t3_grant_count", 64'(grant_log.size()), 64'(8));
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
`ifdef SPI_ARB_RR_EN
            check("t3_grant_seq", 64'(grant_log[i]), 64'(i % 2));
`else
            check("t3_grant_seq", 64'(grant_log[i]), 64'(i >= 4 ? 1 : 0));
`endif
        end

        // 4: busy never rises
        busy_mode = 1;
        push_cmd(0, 16'h4321, 16'h1111, 1, 0);
        wait_done(300, "t4");
        check("t4_latency", 64'(last_lat), 64'(ACK_TMO));
        check("t4_rsp", 64'({last_rsp_err, last_rsp_dat}), 64'({1'b1, 16'h0000}));

        // 5: busy stuck high
        busy_mode = 2; stuck_release = 0;
        r0c = n_rsp;
        push_cmd(1, 16'h0F0F, 16'h2222, 1, 1);
        wait_rsp(r0c + 1, BUSY_TMO + 200, "t5");
        t5_wd = last_wd; t5_err = last_rsp_err; t5_dat = last_rsp_dat;
        check("t5_wait_done_cycles", 64'(t5_wd), 64'(BUSY_TMO));
        check("t5_rsp", 64'({t5_err, t5_dat}), 64'({1'b1, 16'h0000}));
        busy_mode = 0; busy_len = 4;
        push_cmd(0, 16'h0A0A, 16'h3333, 1, 0);
        repeat (5) @(negedge aclk);
        check("t5_foreign_busy", 64'({arb_state_o, spi_busy, r0_ready, r1_ready}), 64'({3'd0, 1'b1, 1'b0, 1'b0}));
        stuck_release = 1;
        wait_done(300, "t5b");
        check("t5_next_rsp", 64'({last_rsp_id, last_rsp_err, last_rsp_dat}),
              64'({1'b0, 1'b0, model_rd(16'h0A0A)}));

        // 6: reset in WAIT_DONE
        busy_mode = 0; busy_len = 40;
        push_cmd(0, 16'h1234, 16'h5678, 0, 1);
        begin
            int n = 0;
            while (arb_state_o != 3'd3 && n < 100) begin
                @(negedge aclk);
                n++;
            end
            if (arb_state_o != 3'd3) check("t6_reach_wait_done_timeout", 64'(0), 64'(1));
        end
        repeat (5) @(negedge aclk);
        r0c = n_rsp;
        aresetn = 0;
        exp_q.delete();
        rr_fav = 0;
        #1;
        check("t6_reset_outputs", 64'({spi_start_o, spi_adr, spi_dat, spi_rw, spi_cs_sel, rsp_valid,
                                       rsp_id, rsp_dat, rsp_err, arb_state_o, r0_ready, r1_ready}), 64'(0));
        repeat (3) @(negedge aclk);
        aresetn = 1;
        wait_done(200, "t6_drain");
        check("t6_no_rsp", 64'(n_rsp - r0c), 64'(0));
        busy_len = 6;
        push_cmd(0, 16'h2468, 16'h1357, 1, 1);
        wait_done(300, "t6_after");
        check("t6_after_rsp", 64'({n_rsp - r0c, last_rsp_id, last_rsp_err, last_rsp_dat}),
              64'({32'd1, 1'b0, 1'b0, model_rd(16'h2468)}));

        // Randomized traffic
        base = n_rsp; n_push = 0;
        for (int i = 0; i < 40; i++) begin
            int m;
            m = int'($urandom_range(1, 3));
            busy_len = int'($urandom_range(1, 12));
            if (m[0]) begin
                push_cmd(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                n_push++;
            end
            if (m[1]) begin
                push_cmd(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                n_push++;
            end
            repeat ($urandom_range(0, 20)) @(negedge aclk);
        end
        wait_done(10000, "rand");
        check("rand_rsp_count", 64'(n_rsp - base), 64'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
